// File: rtl/tvc_pkg.sv
// Shared types and constants for the Triangles-vs-Circles game (sequencer, board datapath, VGA overlay).
package tvc_pkg;

  localparam int BOARD_SIZE = 10;
  localparam int MAX_MOVES  = 25;
  localparam int COORD_W    = 4;

  typedef enum logic [1:0] {
    EMPTY    = 2'b00,
    TRIANGLE = 2'b01,
    CIRCLE   = 2'b10,
    OCCUPIED = 2'b11
  } piece_t;

  typedef enum logic [1:0] {
    OUT_NONE = 2'b00,
    OUT_TRI  = 2'b01,
    OUT_CIR  = 2'b10,
    OUT_DRAW = 2'b11
  } outcome_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ENTRY     = 3'd1,
    ST_REQUEST   = 3'd2,
    ST_GAME_OVER = 3'd3
  } seq_state_t;

  // current_player is 1 for triangles, 0 for circles.
  function automatic piece_t player_piece(input logic player);
    return player ? TRIANGLE : CIRCLE;
  endfunction

  function automatic outcome_t player_win(input logic player);
    return player ? OUT_TRI : OUT_CIR;
  endfunction

endpackage

// File: rtl/button_edge.sv
// Rising-edge detector for a debounced, clk-synchronous button level.
module button_edge (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic rise
);

  logic prev;

  // NOTE: prev resets to 1 so a button held through reset release is not seen as a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= 1'b1;
    else        prev <= button;
  end

  assign rise = button & ~prev;

endmodule

// File: rtl/move_sequencer.sv
// Turn and move-entry controller: assembles coordinates from button presses and
// issues one placement request per turn to the board, tracking moves and game end.
module move_sequencer #(
  parameter int BOARD_SIZE = tvc_pkg::BOARD_SIZE,
  parameter int MAX_MOVES  = tvc_pkg::MAX_MOVES,
  parameter int COORD_W    = tvc_pkg::COORD_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 logic_0_button,
  input  logic                 logic_1_button,
  input  logic                 activity_button,
  input  logic                 place_done,
  input  logic                 place_ok,
  input  logic                 place_win,
  output logic                 clear_board,
  output logic                 place_req,
  output logic [COORD_W-1:0]   move_x,
  output logic [COORD_W-1:0]   move_y,
  output logic [1:0]           move_piece,
  output logic                 current_player,
  output logic [2*COORD_W-1:0] entry_buf,
  output logic [3:0]           entry_count,
  output logic                 invalid_move,
  output logic [4:0]           moves_tri,
  output logic [4:0]           moves_cir,
  output logic [1:0]           game_outcome,
  output logic [2:0]           seq_state
);

  import tvc_pkg::*;

  localparam logic [3:0] FULL_COUNT = 4'(2 * COORD_W);
  localparam logic [4:0] MOVE_LIMIT = 5'(MAX_MOVES);

  logic l0_edge, l1_edge, act_edge;

  button_edge u_l0_edge  (.clk(clk), .reset(reset), .button(logic_0_button),  .rise(l0_edge));
  button_edge u_l1_edge  (.clk(clk), .reset(reset), .button(logic_1_button),  .rise(l1_edge));
  button_edge u_act_edge (.clk(clk), .reset(reset), .button(activity_button), .rise(act_edge));

  seq_state_t state;
  piece_t     piece_q;
  outcome_t   outcome_q;

  logic [COORD_W-1:0] entry_x, entry_y;
  logic               coords_ok;
  logic               bit_edge;
  logic [4:0]         mover_next;
  logic               other_full;

  assign entry_x    = entry_buf[2*COORD_W-1:COORD_W];
  assign entry_y    = entry_buf[COORD_W-1:0];
  assign coords_ok  = (entry_count == FULL_COUNT) &&
                      (int'(entry_x) < BOARD_SIZE) && (int'(entry_y) < BOARD_SIZE);
  // Simultaneous 0 and 1 presses are ambiguous and dropped together.
  assign bit_edge   = l0_edge ^ l1_edge;
  assign mover_next = (current_player ? moves_tri : moves_cir) + 5'd1;
  // Triangles always move first, so the draw lands on the circles' final move.
  assign other_full = (current_player ? moves_cir : moves_tri) == MOVE_LIMIT;

  // NOTE: every register here uses non-blocking assignment so all updates take effect together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      current_player <= 1'b1;
      clear_board    <= 1'b0;
      invalid_move   <= 1'b0;
      move_x         <= '0;
      move_y         <= '0;
      piece_q        <= EMPTY;
      entry_buf      <= '0;
      entry_count    <= '0;
      moves_tri      <= '0;
      moves_cir      <= '0;
      outcome_q      <= OUT_NONE;
    end else begin
      clear_board  <= 1'b0;
      invalid_move <= 1'b0;
      case (state)
        ST_IDLE: if (act_edge) begin
          clear_board    <= 1'b1;
          moves_tri      <= '0;
          moves_cir      <= '0;
          outcome_q      <= OUT_NONE;
          entry_buf      <= '0;
          entry_count    <= '0;
          current_player <= 1'b1;
          state          <= ST_ENTRY;
        end
        ST_ENTRY: begin
          if (act_edge) begin
            if (!coords_ok) begin
              invalid_move <= 1'b1;
              entry_buf    <= '0;
              entry_count  <= '0;
            end else begin
              move_x  <= entry_x;
              move_y  <= entry_y;
              piece_q <= player_piece(current_player);
              state   <= ST_REQUEST;
            end
          end else if (bit_edge && entry_count != FULL_COUNT) begin
            entry_buf   <= {entry_buf[2*COORD_W-2:0], l1_edge};
            entry_count <= entry_count + 4'd1;
          end
        end
        ST_REQUEST: if (place_done) begin
          if (!place_ok) begin
            invalid_move <= 1'b1;
            entry_buf    <= '0;
            entry_count  <= '0;
            state        <= ST_ENTRY;
          end else begin
            if (current_player) moves_tri <= mover_next;
            else                moves_cir <= mover_next;
            if (place_win) begin
              outcome_q <= player_win(current_player);
              state     <= ST_GAME_OVER;
            end else if (mover_next == MOVE_LIMIT && other_full) begin
              outcome_q <= OUT_DRAW;
              state     <= ST_GAME_OVER;
            end else begin
              current_player <= ~current_player;
              entry_buf      <= '0;
              entry_count    <= '0;
              state          <= ST_ENTRY;
            end
          end
        end
        ST_GAME_OVER: if (act_edge) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Derived from state so an asynchronous reset withdraws the request immediately.
  assign place_req    = (state == ST_REQUEST);
  assign move_piece   = piece_q;
  assign game_outcome = outcome_q;
  assign seq_state    = state;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: directed scenarios plus randomized games
// checked against a turn-level model of the game rules.
module tb_move_sequencer;

  logic       clk = 1'b0, reset = 1'b0;
  logic       l0 = 1'b0, l1 = 1'b0, act = 1'b0;
  logic       place_done = 1'b0, place_ok = 1'b0, place_win = 1'b0;
  logic       clear_board, place_req, current_player, invalid_move;
  logic [3:0] move_x, move_y, entry_count;
  logic [1:0] move_piece, game_outcome;
  logic [7:0] entry_buf;
  logic [4:0] moves_tri, moves_cir;
  logic [2:0] seq_state;
  logic [40:0] all_out;

  localparam logic [40:0] RESET_VEC = {3'd0, 1'b1, 37'd0};

  move_sequencer dut (
    .clk(clk), .reset(reset),
    .logic_0_button(l0), .logic_1_button(l1), .activity_button(act),
    .place_done(place_done), .place_ok(place_ok), .place_win(place_win),
    .clear_board(clear_board), .place_req(place_req),
    .move_x(move_x), .move_y(move_y), .move_piece(move_piece),
    .current_player(current_player), .entry_buf(entry_buf), .entry_count(entry_count),
    .invalid_move(invalid_move), .moves_tri(moves_tri), .moves_cir(moves_cir),
    .game_outcome(game_outcome), .seq_state(seq_state)
  );

  assign all_out = {seq_state, current_player, place_req, clear_board, invalid_move,
                    move_x, move_y, move_piece, entry_buf, entry_count,
                    moves_tri, moves_cir, game_outcome};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       obs_clear, obs_inv, obs_req;
  logic [3:0] cap_x, cap_y;
  logic [1:0] cap_piece;
  logic       cap_inv, cap_req, cap_held;

  // Turn-level model: whose turn, move tallies, outcome, bits typed so far.
  int m_player, m_tri, m_cir, m_outcome;
  int m_bits[$];

  function automatic int model_val();
    int v = 0;
    foreach (m_bits[i]) v = (v << 1) | m_bits[i];
    return v;
  endfunction

  // which: 0 -> logic_0, 1 -> logic_1, 2 -> activity, 3 -> logic_0 and logic_1 together.
  task automatic press(input int which);
    @(negedge clk);
    l0  = (which == 0 || which == 3);
    l1  = (which == 1 || which == 3);
    act = (which == 2);
    @(negedge clk);
    obs_clear = clear_board;
    obs_inv   = invalid_move;
    obs_req   = place_req;
    l0 = 1'b0; l1 = 1'b0; act = 1'b0;
  endtask

  task automatic enter_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      press(v[i] ? 1 : 0);
      if (m_bits.size() < 8) m_bits.push_back(int'(v[i]));
    end
  endtask

  task automatic handshake(input logic ok, input logic win, input int delay, output logic got);
    int n = 0;
    got = 1'b0;
    while (place_req !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (place_req === 1'b1) begin
      for (int i = 0; i < delay; i++) @(negedge clk);
      cap_x = move_x; cap_y = move_y; cap_piece = move_piece; cap_held = place_req;
      place_done = 1'b1; place_ok = ok; place_win = win;
      @(negedge clk);
      place_done = 1'b0; place_ok = 1'b0; place_win = 1'b0;
      cap_inv = invalid_move;
      cap_req = place_req;
      got = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    act = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (all_out !== RESET_VEC) begin errors++; $display("FAIL reset_values got %h exp %h", all_out, RESET_VEC); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL held_button_no_press state got %0d exp 0", seq_state); end
    act = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start();
    press(2);
    checks++; if (obs_clear !== 1'b1) begin errors++; $display("FAIL start_clear got %b exp 1", obs_clear); end
    checks++; if (seq_state !== 3'd1) begin errors++; $display("FAIL start_state got %0d exp 1", seq_state); end
    checks++; if ({current_player, moves_tri, moves_cir, game_outcome} !== 13'h1000)
      begin errors++; $display("FAIL start_player_counts got %b/%0d/%0d/%0d exp 1/0/0/0", current_player, moves_tri, moves_cir, game_outcome); end
    @(negedge clk);
    checks++; if (clear_board !== 1'b0) begin errors++; $display("FAIL clear_one_cycle got %b exp 0", clear_board); end
  endtask

  task automatic test_valid_move();
    logic got;
    enter_bits(8'h35, 8);
    checks++; if ({entry_buf, entry_count} !== {8'h35, 4'd8}) begin errors++; $display("FAIL entry_35 got %h/%0d exp 35/8", entry_buf, entry_count); end
    press(1);
    checks++; if ({entry_buf, entry_count} !== {8'h35, 4'd8}) begin errors++; $display("FAIL ninth_bit_dropped got %h/%0d exp 35/8", entry_buf, entry_count); end
    press(2);
    checks++; if (obs_req !== 1'b1 || obs_inv !== 1'b0) begin errors++; $display("FAIL req_latency req %b inv %b exp 1 0", obs_req, obs_inv); end
    handshake(1'b1, 1'b0, 0, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL valid_req_timeout got %b exp 1", got); end
    checks++; if ({cap_x, cap_y, cap_piece} !== {4'd3, 4'd5, 2'b01}) begin errors++; $display("FAIL valid_req_fields got %0d,%0d,%b exp 3,5,01", cap_x, cap_y, cap_piece); end
    checks++; if (cap_req !== 1'b0) begin errors++; $display("FAIL req_drop got %b exp 0", cap_req); end
    checks++; if ({moves_tri, current_player, entry_count, seq_state} !== {5'd1, 1'b0, 4'd0, 3'd1})
      begin errors++; $display("FAIL after_move got tri %0d pl %b cnt %0d st %0d exp 1 0 0 1", moves_tri, current_player, entry_count, seq_state); end
  endtask

  task automatic test_invalid_entry();
    enter_bits(8'b101, 3);
    press(3);
    checks++; if ({entry_buf, entry_count} !== {8'd5, 4'd3}) begin errors++; $display("FAIL both_bits_dropped got %h/%0d exp 05/3", entry_buf, entry_count); end
    enter_bits(8'b10, 2);
    press(2);
    checks++; if ({obs_inv, obs_req, entry_count, seq_state} !== {1'b1, 1'b0, 4'd0, 3'd1})
      begin errors++; $display("FAIL short_entry got inv %b req %b cnt %0d st %0d exp 1 0 0 1", obs_inv, obs_req, entry_count, seq_state); end
    enter_bits(8'hC3, 8);
    press(2);
    checks++; if ({obs_inv, obs_req, entry_count} !== {1'b1, 1'b0, 4'd0}) begin errors++; $display("FAIL x12_entry got inv %b req %b cnt %0d exp 1 0 0", obs_inv, obs_req, entry_count); end
    enter_bits(8'h3A, 8);
    press(2);
    checks++; if ({obs_inv, obs_req, entry_count} !== {1'b1, 1'b0, 4'd0}) begin errors++; $display("FAIL y10_entry got inv %b req %b cnt %0d exp 1 0 0", obs_inv, obs_req, entry_count); end
    checks++; if ({current_player, moves_tri, moves_cir} !== {1'b0, 5'd1, 5'd0}) begin errors++; $display("FAIL invalid_keeps_turn got %b/%0d/%0d exp 0/1/0", current_player, moves_tri, moves_cir); end
  endtask

  task automatic test_place_reject();
    logic got;
    enter_bits(8'h11, 8);
    press(2);
    press(2);
    press(1);
    checks++; if ({seq_state, place_req, entry_buf, entry_count} !== {3'd2, 1'b1, 8'h11, 4'd8})
      begin errors++; $display("FAIL request_ignores_buttons got st %0d req %b buf %h cnt %0d exp 2 1 11 8", seq_state, place_req, entry_buf, entry_count); end
    handshake(1'b0, 1'b0, 1, got);
    checks++; if (got !== 1'b1 || cap_held !== 1'b1) begin errors++; $display("FAIL reject_req got %b held %b exp 1 1", got, cap_held); end
    checks++; if ({cap_inv, cap_req, cap_piece} !== {1'b1, 1'b0, 2'b10}) begin errors++; $display("FAIL reject_pulse got inv %b req %b piece %b exp 1 0 10", cap_inv, cap_req, cap_piece); end
    checks++; if ({current_player, moves_tri, moves_cir, seq_state, entry_count} !== {1'b0, 5'd1, 5'd0, 3'd1, 4'd0})
      begin errors++; $display("FAIL reject_state got pl %b tri %0d cir %0d st %0d cnt %0d exp 0 1 0 1 0", current_player, moves_tri, moves_cir, seq_state, entry_count); end
  endtask

  task automatic test_win();
    logic got;
    enter_bits(8'h22, 8);
    press(2);
    handshake(1'b1, 1'b0, 0, got);
    checks++; if ({got, moves_cir, current_player} !== {1'b1, 5'd1, 1'b1}) begin errors++; $display("FAIL circle_move got %b/%0d/%b exp 1/1/1", got, moves_cir, current_player); end
    enter_bits(8'h99, 8);
    press(2);
    handshake(1'b1, 1'b1, 2, got);
    checks++; if ({got, cap_x, cap_y} !== {1'b1, 4'd9, 4'd9}) begin errors++; $display("FAIL win_req got %b %0d,%0d exp 1 9,9", got, cap_x, cap_y); end
    checks++; if ({game_outcome, seq_state, moves_tri} !== {2'b01, 3'd3, 5'd2}) begin errors++; $display("FAIL tri_win got out %b st %0d tri %0d exp 01 3 2", game_outcome, seq_state, moves_tri); end
    press(2);
    checks++; if ({seq_state, game_outcome} !== {3'd0, 2'b01}) begin errors++; $display("FAIL over_to_idle got st %0d out %b exp 0 01", seq_state, game_outcome); end
    press(2);
    checks++; if ({obs_clear, seq_state, game_outcome, moves_tri, moves_cir} !== {1'b1, 3'd1, 2'b00, 10'd0})
      begin errors++; $display("FAIL restart got clr %b st %0d out %b tri %0d cir %0d exp 1 1 00 0 0", obs_clear, seq_state, game_outcome, moves_tri, moves_cir); end
  endtask

  // Plays one game from a fresh start until it ends; wins are injected only when allow_win.
  task automatic test_random_game(input logic allow_win);
    logic got, ok, win, exp_valid;
    logic [7:0] v;
    int kind, n, x, y, iter;
    m_player = 1; m_tri = 0; m_cir = 0; m_outcome = 0;
    m_bits.delete();
    iter = 0;
    while (m_outcome == 0 && iter < 600) begin
      iter++;
      kind = int'($urandom % 10);
      if (kind == 0) begin
        n = int'($urandom_range(0, 7));
        v = 8'($urandom);
        enter_bits(v, n);
      end else begin
        x = (kind == 1) ? int'($urandom_range(10, 15)) : int'($urandom % 10);
        y = (kind == 2) ? int'($urandom_range(10, 15)) : int'($urandom % 10);
        v = 8'((x << 4) | y);
        enter_bits(v, 8);
        if ($urandom % 4 == 0) enter_bits(8'($urandom), 1);
      end
      checks++; if ({entry_buf, entry_count} !== {8'(model_val()), 4'(m_bits.size())})
        begin errors++; $display("FAIL rnd_entry got %h/%0d exp %h/%0d", entry_buf, entry_count, model_val(), m_bits.size()); end
      exp_valid = (m_bits.size() == 8) && (model_val() / 16 < 10) && (model_val() % 16 < 10);
      x = model_val() / 16;
      y = model_val() % 16;
      press(2);
      m_bits.delete();
      if (!exp_valid) begin
        checks++; if ({obs_inv, obs_req, entry_count, seq_state} !== {1'b1, 1'b0, 4'd0, 3'd1})
          begin errors++; $display("FAIL rnd_invalid got inv %b req %b cnt %0d st %0d exp 1 0 0 1", obs_inv, obs_req, entry_count, seq_state); end
      end else begin
        ok  = ($urandom % 5 != 0);
        win = allow_win && ($urandom % 12 == 0);
        handshake(ok, win, int'($urandom % 3), got);
        checks++; if (got !== 1'b1 || obs_req !== 1'b1) begin errors++; $display("FAIL rnd_req_seen got %b/%b exp 1/1", got, obs_req); end
        checks++; if ({cap_x, cap_y, cap_piece, cap_req, cap_inv} !== {4'(x), 4'(y), (m_player == 1) ? 2'b01 : 2'b10, 1'b0, ~ok})
          begin errors++; $display("FAIL rnd_req got %0d,%0d,%b req %b inv %b exp %0d,%0d pl %0d ok %b", cap_x, cap_y, cap_piece, cap_req, cap_inv, x, y, m_player, ok); end
        if (ok) begin
          if (m_player == 1) m_tri++; else m_cir++;
          if (win) m_outcome = (m_player == 1) ? 1 : 2;
          else if (m_tri == 25 && m_cir == 25) m_outcome = 3;
          else m_player = 1 - m_player;
        end
      end
      checks++; if ({moves_tri, moves_cir, current_player, game_outcome, seq_state} !== {5'(m_tri), 5'(m_cir), 1'(m_player), 2'(m_outcome), (m_outcome != 0) ? 3'd3 : 3'd1})
        begin errors++; $display("FAIL rnd_turn got tri %0d cir %0d pl %b out %b st %0d exp %0d %0d %0d %0d", moves_tri, moves_cir, current_player, game_outcome, seq_state, m_tri, m_cir, m_player, m_outcome); end
    end
    checks++; if (m_outcome == 0) begin errors++; $display("FAIL rnd_game_end got no outcome after %0d turns exp game over", iter); end
    if (!allow_win) begin
      checks++; if ({game_outcome, moves_tri, moves_cir} !== {2'b11, 5'd25, 5'd25})
        begin errors++; $display("FAIL draw got out %b tri %0d cir %0d exp 11 25 25", game_outcome, moves_tri, moves_cir); end
    end
    press(2);
    press(2);
    checks++; if ({obs_clear, seq_state, game_outcome} !== {1'b1, 3'd1, 2'b00}) begin errors++; $display("FAIL rnd_restart got %b %0d %b exp 1 1 00", obs_clear, seq_state, game_outcome); end
  endtask

  task automatic test_reset_mid_request();
    enter_bits(8'h47, 8);
    press(2);
    checks++; if (place_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req got %b exp 1", place_req); end
    #2 reset = 1'b0;
    #1;
    checks++; if (place_req !== 1'b0) begin errors++; $display("FAIL async_req_drop got %b exp 0", place_req); end
    checks++; if (all_out !== RESET_VEC) begin errors++; $display("FAIL mid_reset_values got %h exp %h", all_out, RESET_VEC); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_start();
    test_valid_move();
    test_invalid_entry();
    test_place_reject();
    test_win();
    test_random_game(1'b0);
    test_random_game(1'b1);
    test_reset_mid_request();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "bench timed out");
  end

endmodule
